wallclock_timebase: RTL and testbench

- Parametrised successor to the 1 s clock divider. Derives a 1 ms prescaler and a 0..999 ms counter from the system clock at any multiple-of-1 kHz frequency, plus the 50 % clk_1s square wave.
- Extends that with run/stop, a BCD hh:mm:ss time-of-day chain, validated time load, and a 12/24-hour display mode.
- Sits between the board clock and the wall-clock display/scan logic.

---
 rtl/wallclock_pkg.sv | 36 +++
 rtl/wallclock_timebase_bcd_mod_counter.sv | 33 +++
 rtl/wallclock_timebase.sv | 141 ++++++++++++++
 tb/tb_wallclock_timebase.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wallclock_pkg.sv
// Shared constants and BCD helpers for the wall-clock timebase.
package wallclock_pkg;

  localparam int MS_PER_S = 1000;
  localparam int MS_HALF  = 500;

  localparam logic [7:0] SEC_MAX_BCD  = 8'h59;
  localparam logic [7:0] MIN_MAX_BCD  = 8'h59;
  localparam logic [7:0] HOUR_MAX_BCD = 8'h23;

  // Both nibbles must be decimal digits before the magnitude compare is meaningful.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

  // Returns {carry, next}; carry is set only when 99 wraps to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] value);
    logic [3:0] lo;
    logic [3:0] hi;
    logic       carry;
    carry = 1'b0;
    hi    = value[7:4];
    lo    = value[3:0] + 4'd1;
    if (value[3:0] == 4'd9) begin
      lo = 4'd0;
      if (hi == 4'd9) begin
        hi    = 4'd0;
        carry = 1'b1;
      end else begin
        hi = hi + 4'd1;
      end
    end
    return {carry, hi, lo};
  endfunction

endpackage

// File: rtl/wallclock_timebase_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX_BCD, with a synchronous load that
// overrides counting.
module bcd_mod_counter
  import wallclock_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       carry
);

  logic [8:0] inc_val;

  assign inc_val = bcd_inc(q);
  // The 99 -> 00 wrap also counts as terminal so a MAX_BCD of 8'h99 still carries.
  assign carry   = inc && ((q == MAX_BCD) || inc_val[8]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= carry ? 8'h00 : inc_val[7:0];
    end
  end

endmodule

// File: rtl/wallclock_timebase.sv
// 1 ms prescaler, 0..999 ms counter, 1 Hz square wave and a BCD hh:mm:ss
// time-of-day chain with validated load and 12/24-hour display.
module wallclock_timebase
  import wallclock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int MS_W   = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            mode12,
  input  logic            load,
  input  logic [7:0]      load_hour,
  input  logic [7:0]      load_min,
  input  logic [7:0]      load_sec,
  output logic [MS_W-1:0] ms,
  output logic            ms_tick,
  output logic            sec_tick,
  output logic            clk_1s,
  output logic [7:0]      sec_bcd,
  output logic [7:0]      min_bcd,
  output logic [7:0]      hour_bcd,
  output logic            pm,
  output logic            day_tick,
  output logic            load_err
);

  localparam int DIV   = CLK_HZ / 1000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  if ((CLK_HZ % 1000 != 0) || (CLK_HZ < 2000) || (MS_W < 10)) begin : g_bad_param
    $error("wallclock_timebase: CLK_HZ must be a multiple of 1000 and >= 2000, MS_W >= 10");
  end

  logic [PRE_W-1:0] pre;
  logic             load_ok;
  logic             pre_wrap;
  logic             ms_wrap;
  logic [MS_W-1:0]  ms_next;
  logic             sec_carry;
  logic             min_carry;
  logic             hour_carry;
  logic [7:0]       hour_q;
  logic [4:0]       hour_bin;
  logic [4:0]       hour_pm;

  assign load_ok = load && bcd_valid(load_hour, HOUR_MAX_BCD)
                        && bcd_valid(load_min, MIN_MAX_BCD)
                        && bcd_valid(load_sec, SEC_MAX_BCD);

  // A valid load suppresses the whole tick chain on its edge.
  assign pre_wrap = run && !load_ok && (pre == PRE_W'(DIV - 1));
  assign ms_wrap  = pre_wrap && (ms == MS_W'(MS_PER_S - 1));

  always_comb begin
    ms_next = ms;
    if (load_ok || ms_wrap) begin
      ms_next = '0;
    end else if (pre_wrap) begin
      ms_next = ms + MS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre      <= '0;
      ms       <= '0;
      ms_tick  <= 1'b0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      clk_1s   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      ms       <= ms_next;
      clk_1s   <= (ms_next >= MS_W'(MS_HALF));
      ms_tick  <= pre_wrap;
      sec_tick <= ms_wrap;
      day_tick <= hour_carry;
      load_err <= load && !load_ok;
      if (load_ok) begin
        pre <= '0;
      end else if (run) begin
        pre <= (pre == PRE_W'(DIV - 1)) ? '0 : pre + PRE_W'(1);
      end
    end
  end

  bcd_mod_counter #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (ms_wrap),
    .load     (load_ok),
    .load_val (load_sec),
    .q        (sec_bcd),
    .carry    (sec_carry)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_carry),
    .load     (load_ok),
    .load_val (load_min),
    .q        (min_bcd),
    .carry    (min_carry)
  );

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .inc      (min_carry),
    .load     (load_ok),
    .load_val (load_hour),
    .q        (hour_q),
    .carry    (hour_carry)
  );

  // Display conversion is purely combinational so mode12 never disturbs time.
  always_comb begin
    hour_bcd = hour_q;
    pm       = 1'b0;
    case (hour_q[7:4])
      4'd2:    hour_bin = 5'd20 + 5'(hour_q[3:0]);
      4'd1:    hour_bin = 5'd10 + 5'(hour_q[3:0]);
      default: hour_bin = 5'(hour_q[3:0]);
    endcase
    hour_pm = hour_bin - 5'd12;
    if (mode12) begin
      if (hour_bin == 5'd0) begin
        hour_bcd = 8'h12;
      end else if (hour_bin >= 5'd12) begin
        pm = 1'b1;
        if (hour_bin != 5'd12) begin
          hour_bcd = (hour_pm >= 5'd10) ? {4'h1, 4'(hour_pm - 5'd10)} : {4'h0, hour_pm[3:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_wallclock_timebase.sv
// Directed and randomized bench for wallclock_timebase at CLK_HZ=10_000 against
// a time-of-day model that counts seconds since midnight.
module tb_wallclock_timebase;

  localparam int CLK_HZ = 10_000;
  localparam int MS_W   = 12;
  localparam int DIV    = CLK_HZ / 1000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            run = 1'b0;
  logic            mode12 = 1'b0;
  logic            load = 1'b0;
  logic [7:0]      load_hour = 8'h00;
  logic [7:0]      load_min = 8'h00;
  logic [7:0]      load_sec = 8'h00;
  logic [MS_W-1:0] ms;
  logic            ms_tick, sec_tick, clk_1s, pm, day_tick, load_err;
  logic [7:0]      sec_bcd, min_bcd, hour_bcd;

  int tests = 0;
  int fails = 0;

  int m_pre, m_ms, m_tod;
  bit m_ms_tick, m_sec_tick, m_day_tick, m_err;

  wallclock_timebase #(.CLK_HZ(CLK_HZ), .MS_W(MS_W)) dut (
    .clk(clk), .reset(reset), .run(run), .mode12(mode12), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .ms(ms), .ms_tick(ms_tick), .sec_tick(sec_tick), .clk_1s(clk_1s),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .pm(pm),
    .day_tick(day_tick), .load_err(load_err)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int maxv);
    return (int'(v[7:4]) <= 9) && (int'(v[3:0]) <= 9) && (from_bcd(v) <= maxv);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_ms = 0; m_tod = 0;
    m_ms_tick = 0; m_sec_tick = 0; m_day_tick = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ok;
    ok = field_ok(load_hour, 23) && field_ok(load_min, 59) && field_ok(load_sec, 59);
    m_ms_tick = 0; m_sec_tick = 0; m_day_tick = 0;
    m_err = load && !ok;
    if (load && ok) begin
      m_tod = from_bcd(load_hour) * 3600 + from_bcd(load_min) * 60 + from_bcd(load_sec);
      m_pre = 0;
      m_ms  = 0;
    end else if (run) begin
      m_pre++;
      if (m_pre == DIV) begin
        m_pre = 0;
        m_ms_tick = 1;
        m_ms++;
        if (m_ms == 1000) begin
          m_ms = 0;
          m_sec_tick = 1;
          m_tod++;
          if (m_tod == 86400) begin
            m_tod = 0;
            m_day_tick = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int h, eh;
    h  = m_tod / 3600;
    eh = mode12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    chk("ms", ms, m_ms);
    chk("ms_tick", ms_tick, m_ms_tick);
    chk("sec_tick", sec_tick, m_sec_tick);
    chk("day_tick", day_tick, m_day_tick);
    chk("load_err", load_err, m_err);
    chk("clk_1s", clk_1s, (m_ms >= 500));
    chk("sec_bcd", sec_bcd, to_bcd(m_tod % 60));
    chk("min_bcd", min_bcd, to_bcd((m_tod / 60) % 60));
    chk("hour_bcd", hour_bcd, to_bcd(eh));
    chk("pm", pm, (mode12 && h >= 12));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hour = h; load_min = m; load_sec = s; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int n_sec, n_high, n_ticks, guard;
    bit both_seen;

    // Reset held for 5 cycles
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_all();
    mode12 = 1'b1;
    #1;
    chk("rst_hour12", hour_bcd, 8'h12);
    chk("rst_pm12", pm, 1'b0);
    mode12 = 1'b0;
    reset = 1'b1;
    run = 1'b1;

    // First ms tick on the 10th edge after release
    repeat (9) cyc();
    chk("no_tick_yet", ms_tick, 1'b0);
    cyc();
    chk("first_ms_tick", ms_tick, 1'b1);
    chk("first_ms", ms, 12'd1);

    // One full second from reset
    n_sec = 0; n_high = 0;
    for (int i = 0; i < 9990; i++) begin
      cyc();
      if (sec_tick) n_sec++;
      if (clk_1s) n_high++;
    end
    chk("sec_tick_count", n_sec, 1);
    chk("clk_1s_high_cycles", n_high, 5000);
    chk("ms_after_1s", ms, 12'd0);
    chk("sec_after_1s", sec_bcd, 8'h01);

    // Midnight rollover
    do_load(8'h23, 8'h59, 8'h59);
    both_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (sec_tick && day_tick) both_seen = 1;
    end
    chk("day_and_sec_tick", both_seen, 1'b1);
    chk("midnight_hour", hour_bcd, 8'h00);
    chk("midnight_min", min_bcd, 8'h00);
    chk("midnight_sec", sec_bcd, 8'h00);
    mode12 = 1'b1;
    #1;
    chk("midnight_h12", hour_bcd, 8'h12);
    chk("midnight_pm", pm, 1'b0);

    // 12/24-hour display
    do_load(8'h13, 8'h05, 8'h00);
    chk("pm_hour12", hour_bcd, 8'h01);
    chk("pm_flag12", pm, 1'b1);
    mode12 = 1'b0;
    #1;
    chk("pm_hour24", hour_bcd, 8'h13);
    chk("pm_flag24", pm, 1'b0);
    chk("pm_min24", min_bcd, 8'h05);

    // Rejected loads
    do_load(8'h10, 8'h10, 8'h60);
    chk("err_sec60", load_err, 1'b1);
    cyc();
    chk("err_clears", load_err, 1'b0);
    do_load(8'h10, 8'h1A, 8'h00);
    chk("err_min1a", load_err, 1'b1);
    chk("err_keeps_hour", hour_bcd, 8'h13);

    // Hold at ms 437
    guard = 0;
    while (m_ms != 437 && guard < 12000) begin
      cyc();
      guard++;
    end
    chk("reach_ms_437", ms, 12'd437);
    run = 1'b0;
    n_ticks = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ms_tick || sec_tick || day_tick) n_ticks++;
    end
    chk("stopped_ticks", n_ticks, 0);
    chk("stopped_ms", ms, 12'd437);
    do_load(8'h07, 8'h30, 8'h15);
    chk("stopped_load_ms", ms, 12'd0);
    chk("stopped_load_clk1s", clk_1s, 1'b0);
    chk("stopped_load_min", min_bcd, 8'h30);
    run = 1'b1;
    repeat (5500) cyc();
    chk("resumed_clk1s", clk_1s, 1'b1);

    // Asynchronous reset between edges
    @(posedge clk);
    model_step();
    #5;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_min", min_bcd, 8'h00);
    #2;
    reset = 1'b1;

    // Randomized run/load/mode traffic
    do_load(8'h23, 8'h59, 8'h58);
    for (int i = 0; i < 13000; i++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) mode12 = ~mode12;
      if ($urandom_range(0, 99) == 0) begin
        load_hour = 8'($urandom);
        load_min  = 8'($urandom);
        load_sec  = 8'($urandom);
        load = 1'b1;
      end else if ($urandom_range(0, 3999) == 0) begin
        load_hour = to_bcd($urandom_range(0, 23));
        load_min  = to_bcd($urandom_range(0, 59));
        load_sec  = to_bcd($urandom_range(0, 59));
        load = 1'b1;
      end
      cyc();
      load = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
